// File: rtl/commit_unit.sv
// ---------------------------------------------------------------------------
// commit_unit
//   In-order retirement stage. Each decoded instruction gets one slot in a
//   circular completion buffer, addressed by the IQ position that travels
//   with it on the issue buses. The three writeback buses mark slots done.
//   Done instructions then retire in program order to the register file and
//   the store port.
//
// Optional feature macro: COMMIT_DUAL_EN
//   defined   : up to two retirements per cycle (cm0 + cm1)
//   undefined : only cm0 retires; all cm1_* outputs are tied to 0
//
// Ports
//   clk, nrst                  clock, asynchronous active-low reset
//   flush                      discard every in-flight slot
//   alloc_valid/reg_we/rd_addr/store
//                              allocation request for the slot at the tail
//   alloc_ready, alloc_pos     a slot is free / position assigned (tail)
//   wbK_valid/pos/data         writeback bus K (K = 0..2)
//   cmJ_valid/reg_we/rd_addr/data/store
//                              registered retirement J (J = 0..1)
//   count                      occupied slots
//   wb_err                     sticky writeback error flag
// ---------------------------------------------------------------------------
module commit_unit #(
  parameter int DEPTH  = 8,
  parameter int POS_W  = 3,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_reg_we,
  input  logic [RA_W-1:0]   alloc_rd_addr,
  input  logic              alloc_store,
  output logic              alloc_ready,
  output logic [POS_W-1:0]  alloc_pos,
  input  logic              wb0_valid,
  input  logic [POS_W-1:0]  wb0_pos,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [POS_W-1:0]  wb1_pos,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              wb2_valid,
  input  logic [POS_W-1:0]  wb2_pos,
  input  logic [DATA_W-1:0] wb2_data,
  output logic              cm0_valid,
  output logic              cm0_reg_we,
  output logic [RA_W-1:0]   cm0_rd_addr,
  output logic [DATA_W-1:0] cm0_data,
  output logic              cm0_store,
  output logic              cm1_valid,
  output logic              cm1_reg_we,
  output logic [RA_W-1:0]   cm1_rd_addr,
  output logic [DATA_W-1:0] cm1_data,
  output logic              cm1_store,
  output logic [POS_W:0]    count,
  output logic              wb_err
);

  localparam int NUM_WB = 3;

  // Slot state
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  reg_we_q;
  logic [DEPTH-1:0]  store_q;
  logic [RA_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [POS_W-1:0]  head_q, head_d;
  logic [POS_W-1:0]  tail_q;
  logic [POS_W:0]    count_q, count_d;
  logic              wb_err_q;

  logic              cm0_valid_q, cm0_reg_we_q, cm0_store_q;
  logic [RA_W-1:0]   cm0_rd_q;
  logic [DATA_W-1:0] cm0_data_q;

  logic              alloc_fire;
  logic              ret0, ret1;

  // -------------------------------------------------------------------------
  // Allocation: purely from registered tail/count, so a full buffer that
  // retires this cycle still refuses allocation until the next cycle.
  // -------------------------------------------------------------------------
  assign alloc_ready = (count_q != (POS_W+1)'(DEPTH));
  assign alloc_pos   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // -------------------------------------------------------------------------
  // Writeback qualification
  // -------------------------------------------------------------------------
  logic [NUM_WB-1:0] wb_v;
  logic [POS_W-1:0]  wb_p [NUM_WB];
  logic [DATA_W-1:0] wb_d [NUM_WB];
  logic [NUM_WB-1:0] wb_clash;
  logic [NUM_WB-1:0] wb_ok;
  logic              wb_bad;

  assign wb_v    = {wb2_valid, wb1_valid, wb0_valid};
  assign wb_p[0] = wb0_pos;
  assign wb_p[1] = wb1_pos;
  assign wb_p[2] = wb2_pos;
  assign wb_d[0] = wb0_data;
  assign wb_d[1] = wb1_data;
  assign wb_d[2] = wb2_data;

  generate
    for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb
      localparam int J1 = (gi + 1) % NUM_WB;
      localparam int J2 = (gi + 2) % NUM_WB;
      // Buses naming the same position all lose; none of them may update
      // the slot because it is ambiguous which result is correct.
      assign wb_clash[gi] = (wb_v[J1] && (wb_p[J1] == wb_p[gi])) ||
                            (wb_v[J2] && (wb_p[J2] == wb_p[gi]));
      assign wb_ok[gi]    = wb_v[gi] && !wb_clash[gi] &&
                            valid_q[wb_p[gi]] && !done_q[wb_p[gi]];
    end
  endgenerate

  assign wb_bad = |(wb_v & ~wb_ok);

  // -------------------------------------------------------------------------
  // Retire candidates (registered state only)
  // -------------------------------------------------------------------------
  assign ret0 = valid_q[head_q] && done_q[head_q];

`ifdef COMMIT_DUAL_EN
  logic [POS_W-1:0]  head1;
  logic              cm1_valid_q, cm1_reg_we_q, cm1_store_q;
  logic [RA_W-1:0]   cm1_rd_q;
  logic [DATA_W-1:0] cm1_data_q;

  assign head1 = head_q + POS_W'(1);
  // Single store port: a store may only leave through slot 0.
  assign ret1  = ret0 && valid_q[head1] && done_q[head1] && !store_q[head1];

  assign cm1_valid   = cm1_valid_q;
  assign cm1_reg_we  = cm1_reg_we_q;
  assign cm1_rd_addr = cm1_rd_q;
  assign cm1_data    = cm1_data_q;
  assign cm1_store   = cm1_store_q;
`else
  assign ret1        = 1'b0;
  assign cm1_valid   = 1'b0;
  assign cm1_reg_we  = 1'b0;
  assign cm1_rd_addr = '0;
  assign cm1_data    = '0;
  assign cm1_store   = 1'b0;
`endif

  always_comb begin
    head_d = head_q;
    if (ret1)
      head_d = head_q + POS_W'(2);
    else if (ret0)
      head_d = head_q + POS_W'(1);
  end

  assign count_d = count_q + (POS_W+1)'(alloc_fire)
                           - (POS_W+1)'(ret0)
                           - (POS_W+1)'(ret1);

  // -------------------------------------------------------------------------
  // State update. Alloc, writeback and retire never target the same slot in
  // one cycle: the tail slot is invalid whenever allocation fires, and a
  // retiring slot is already done so any writeback to it is rejected.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q      <= '0;
      done_q       <= '0;
      reg_we_q     <= '0;
      store_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wb_err_q     <= 1'b0;
      cm0_valid_q  <= 1'b0;
      cm0_reg_we_q <= 1'b0;
      cm0_rd_q     <= '0;
      cm0_data_q   <= '0;
      cm0_store_q  <= 1'b0;
`ifdef COMMIT_DUAL_EN
      cm1_valid_q  <= 1'b0;
      cm1_reg_we_q <= 1'b0;
      cm1_rd_q     <= '0;
      cm1_data_q   <= '0;
      cm1_store_q  <= 1'b0;
`endif
    end else if (flush) begin
      // Writebacks, retirements and allocation of this cycle are dropped.
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      cm0_valid_q  <= 1'b0;
      cm0_reg_we_q <= 1'b0;
      cm0_rd_q     <= '0;
      cm0_data_q   <= '0;
      cm0_store_q  <= 1'b0;
`ifdef COMMIT_DUAL_EN
      cm1_valid_q  <= 1'b0;
      cm1_reg_we_q <= 1'b0;
      cm1_rd_q     <= '0;
      cm1_data_q   <= '0;
      cm1_store_q  <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_ok[k]) begin
          done_q[wb_p[k]] <= 1'b1;
          data_q[wb_p[k]] <= wb_d[k];
        end
      end

      if (ret0) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
`ifdef COMMIT_DUAL_EN
      if (ret1) begin
        valid_q[head1] <= 1'b0;
        done_q[head1]  <= 1'b0;
      end
`endif

      if (alloc_fire) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        reg_we_q[tail_q] <= alloc_reg_we;
        store_q[tail_q]  <= alloc_store;
        rd_q[tail_q]     <= alloc_rd_addr;
        tail_q           <= tail_q + POS_W'(1);
      end

      head_q   <= head_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_q | wb_bad;

      // Fields are zeroed when nothing retires so idle outputs stay quiet.
      cm0_valid_q  <= ret0;
      cm0_reg_we_q <= ret0 ? reg_we_q[head_q] : 1'b0;
      cm0_rd_q     <= ret0 ? rd_q[head_q]     : '0;
      cm0_data_q   <= ret0 ? data_q[head_q]   : '0;
      cm0_store_q  <= ret0 ? store_q[head_q]  : 1'b0;
`ifdef COMMIT_DUAL_EN
      cm1_valid_q  <= ret1;
      cm1_reg_we_q <= ret1 ? reg_we_q[head1] : 1'b0;
      cm1_rd_q     <= ret1 ? rd_q[head1]     : '0;
      cm1_data_q   <= ret1 ? data_q[head1]   : '0;
      cm1_store_q  <= ret1 ? store_q[head1]  : 1'b0;
`endif
    end
  end

  assign cm0_valid   = cm0_valid_q;
  assign cm0_reg_we  = cm0_reg_we_q;
  assign cm0_rd_addr = cm0_rd_q;
  assign cm0_data    = cm0_data_q;
  assign cm0_store   = cm0_store_q;
  assign count       = count_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_commit_unit
//   Directed bench for commit_unit. Every allocation pushes the expected
//   retirement record onto a scoreboard queue; every retirement seen on
//   cm0/cm1 pops and compares in program order.
// ---------------------------------------------------------------------------
module tb_commit_unit;

  localparam int DEPTH  = 8;
  localparam int POS_W  = 3;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
`ifdef COMMIT_DUAL_EN
  localparam int RATE = 2;
`else
  localparam int RATE = 1;
`endif

  logic              clk = 1'b0;
  logic              nrst;
  logic              flush;
  logic              alloc_valid, alloc_reg_we, alloc_store;
  logic [RA_W-1:0]   alloc_rd_addr;
  logic              alloc_ready;
  logic [POS_W-1:0]  alloc_pos;
  logic              wb0_valid, wb1_valid, wb2_valid;
  logic [POS_W-1:0]  wb0_pos, wb1_pos, wb2_pos;
  logic [DATA_W-1:0] wb0_data, wb1_data, wb2_data;
  logic              cm0_valid, cm0_reg_we, cm0_store;
  logic [RA_W-1:0]   cm0_rd_addr;
  logic [DATA_W-1:0] cm0_data;
  logic              cm1_valid, cm1_reg_we, cm1_store;
  logic [RA_W-1:0]   cm1_rd_addr;
  logic [DATA_W-1:0] cm1_data;
  logic [POS_W:0]    count;
  logic              wb_err;

  commit_unit #(.DEPTH(DEPTH), .POS_W(POS_W), .DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_reg_we(alloc_reg_we),
    .alloc_rd_addr(alloc_rd_addr), .alloc_store(alloc_store),
    .alloc_ready(alloc_ready), .alloc_pos(alloc_pos),
    .wb0_valid(wb0_valid), .wb0_pos(wb0_pos), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_pos(wb1_pos), .wb1_data(wb1_data),
    .wb2_valid(wb2_valid), .wb2_pos(wb2_pos), .wb2_data(wb2_data),
    .cm0_valid(cm0_valid), .cm0_reg_we(cm0_reg_we), .cm0_rd_addr(cm0_rd_addr),
    .cm0_data(cm0_data), .cm0_store(cm0_store),
    .cm1_valid(cm1_valid), .cm1_reg_we(cm1_reg_we), .cm1_rd_addr(cm1_rd_addr),
    .cm1_data(cm1_data), .cm1_store(cm1_store),
    .count(count), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              st;
  } ret_t;

  ret_t              sb[$];
  logic [DATA_W-1:0] plan_data [DEPTH];
  int                checks = 0;
  int                errors = 0;
  int                m_tail = 0;
  int                n_ret  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int lane, input ret_t obs);
    ret_t e;
    $display("retire lane%0d we=%0d rd=%0d data=%h store=%0d",
             lane, obs.we, obs.rd, obs.data, obs.st);
    if (sb.size() == 0) begin
      check("unexpected_retire", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check((lane == 0) ? "cm0_fields" : "cm1_fields", 64'(obs), 64'(e));
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n_ret = 0;
    if (cm0_valid === 1'b1) begin
      n_ret++;
      pop_check(0, {cm0_reg_we, cm0_rd_addr, cm0_data, cm0_store});
    end
`ifndef COMMIT_DUAL_EN
    check("cm1_tied", 64'({cm1_valid, cm1_reg_we, cm1_rd_addr, cm1_data, cm1_store}), 64'd0);
`endif
    if (cm1_valid === 1'b1) begin
      n_ret++;
      pop_check(1, {cm1_reg_we, cm1_rd_addr, cm1_data, cm1_store});
    end
  endtask

  task automatic do_alloc(input logic we, input logic [RA_W-1:0] rd,
                          input logic st, input logic [DATA_W-1:0] d);
    check("alloc_ready", 64'(alloc_ready), 64'd1);
    check("alloc_pos", 64'(alloc_pos), 64'(m_tail));
    alloc_valid   = 1'b1;
    alloc_reg_we  = we;
    alloc_rd_addr = rd;
    alloc_store   = st;
    plan_data[m_tail] = d;
    sb.push_back({we, rd, d, st});
    $display("alloc pos=%0d we=%0d rd=%0d store=%0d data=%h", m_tail, we, rd, st, d);
    m_tail = (m_tail + 1) % DEPTH;
    tick();
    alloc_valid   = 1'b0;
    alloc_reg_we  = 1'b0;
    alloc_rd_addr = '0;
    alloc_store   = 1'b0;
  endtask

  task automatic do_wb(input logic v0, input logic [POS_W-1:0] p0,
                       input logic v1, input logic [POS_W-1:0] p1,
                       input logic v2, input logic [POS_W-1:0] p2);
    wb0_valid = v0; wb0_pos = p0; wb0_data = plan_data[p0];
    wb1_valid = v1; wb1_pos = p1; wb1_data = plan_data[p1];
    wb2_valid = v2; wb2_pos = p2; wb2_data = plan_data[p2];
    $display("writeback v=%0d%0d%0d pos=%0d,%0d,%0d", v0, v1, v2, p0, p1, p2);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0; wb2_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    sb.delete();
    m_tail = 0;
    #2 nrst = 1'b0;
    #1;
    check("async_rst_wb_err", 64'(wb_err), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_cm0", 64'(cm0_valid), 64'd0);
    #1 nrst = 1'b1;
    $display("async reset pulse");
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_reg_we = 1'b0; alloc_rd_addr = '0; alloc_store = 1'b0;
    wb0_valid = 1'b0; wb0_pos = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_pos = '0; wb1_data = '0;
    wb2_valid = 1'b0; wb2_pos = '0; wb2_data = '0;
    for (int i = 0; i < DEPTH; i++) plan_data[i] = '0;

    // Reset values
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_alloc_pos", 64'(alloc_pos), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    check("rst_cm0", 64'({cm0_valid, cm0_reg_we, cm0_rd_addr, cm0_data, cm0_store}), 64'd0);
    check("rst_cm1", 64'({cm1_valid, cm1_reg_we, cm1_rd_addr, cm1_data, cm1_store}), 64'd0);
    #1 nrst = 1'b1;

    // Simple retire
    do_alloc(1'b1, 5'd3, 1'b0, 32'h1234);
    do_wb(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check("simple_no_early", 64'(n_ret), 64'd0);
    tick();
    check("simple_retire", 64'(n_ret), 64'd1);
    check("simple_count", 64'(count), 64'd0);

    // Fill: positions 1..7,0
    for (int i = 0; i < DEPTH; i++) do_alloc(1'b1, 5'(i + 1), 1'b0, 32'hB000 + 32'(i));
    check("full_ready", 64'(alloc_ready), 64'd0);
    check("full_count", 64'(count), 64'd8);
    alloc_valid = 1'b1; alloc_reg_we = 1'b1; alloc_rd_addr = 5'd31;
    tick();
    alloc_valid = 1'b0; alloc_reg_we = 1'b0; alloc_rd_addr = '0;
    check("ninth_count", 64'(count), 64'd8);
    check("ninth_pos", 64'(alloc_pos), 64'd1);

    // Out-of-order completion, newest first, across three buses
    do_wb(1'b1, 3'd0, 1'b1, 3'd7, 1'b1, 3'd6);
    do_wb(1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 3'd3);
    do_wb(1'b1, 3'd2, 1'b1, 3'd1, 1'b0, 3'd0);
    check("fill_hold", 64'(n_ret), 64'd0);
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      tick();
      check("fill_rate", 64'(n_ret), 64'(RATE));
    end
    check("fill_drained", 64'(sb.size()), 64'd0);
    check("fill_count", 64'(count), 64'd0);

    // Refill with wrap of alloc_pos 7 -> 0, then flush back to empty
    for (int i = 0; i < DEPTH; i++) do_alloc(1'b0, 5'd0, 1'b0, 32'hC000 + 32'(i));
    check("refill_pos", 64'(alloc_pos), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    m_tail = 0;
    check("refill_flush_count", 64'(count), 64'd0);
    check("refill_flush_pos", 64'(alloc_pos), 64'd0);

    // Store restriction: slot 1 is a store
    do_alloc(1'b1, 5'd10, 1'b0, 32'hD0);
    do_alloc(1'b0, 5'd0, 1'b1, 32'hD1);
    do_wb(1'b1, 3'd0, 1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    check("store_cycleA", 64'(n_ret), 64'd1);
    tick();
    check("store_cycleB", 64'(n_ret), 64'd1);
    check("store_on_cm0", 64'(cm0_store), 64'd1);

    // Out-of-order: younger done first
    do_alloc(1'b1, 5'd11, 1'b0, 32'hE0);
    do_alloc(1'b1, 5'd12, 1'b0, 32'hE1);
    do_wb(1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0);
    tick();
    check("ooo_hold", 64'(n_ret), 64'd0);
    do_wb(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2);
    check("ooo_wb_edge", 64'(n_ret), 64'd0);
    tick();
    check("ooo_first", 64'(n_ret), 64'(RATE));
`ifndef COMMIT_DUAL_EN
    tick();
    check("ooo_second", 64'(n_ret), 64'd1);
`endif
    check("ooo_drained", 64'(sb.size()), 64'd0);

    // Flush with 5 in flight (2 done) and a concurrent allocation
    for (int i = 0; i < 5; i++) do_alloc(1'b1, 5'(20 + i), 1'b0, 32'hF0 + 32'(i));
    do_wb(1'b1, 3'd5, 1'b1, 3'd7, 1'b0, 3'd0);
    check("flush_pre_count", 64'(count), 64'd5);
    flush = 1'b1; alloc_valid = 1'b1; alloc_reg_we = 1'b1; alloc_rd_addr = 5'd25;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; alloc_reg_we = 1'b0; alloc_rd_addr = '0;
    sb.delete();
    m_tail = 0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_pos", 64'(alloc_pos), 64'd0);
    check("flush_cm", 64'({cm0_valid, cm1_valid}), 64'd0);
    tick();
    check("flush_idle_count", 64'(count), 64'd0);
    do_alloc(1'b1, 5'd13, 1'b0, 32'h1313);
    do_wb(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    check("post_flush_retire", 64'(n_ret), 64'd1);

    // Errors: writeback to a flushed (invalid) slot, then duplicate on done
    check("err_clean", 64'(wb_err), 64'd0);
    do_wb(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0);
    check("err_invalid", 64'(wb_err), 64'd1);
    do_alloc(1'b1, 5'd14, 1'b0, 32'h4242);
    do_wb(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
    wb1_valid = 1'b1; wb1_pos = 3'd1; wb1_data = 32'hDEAD;
    tick();
    wb1_valid = 1'b0;
    check("err_dup_retire", 64'(n_ret), 64'd1);
    check("err_sticky", 64'(wb_err), 64'd1);
    tick();
    check("err_still", 64'(wb_err), 64'd1);
    reset_pulse();

    // Duplicate on done slot alone sets the flag
    do_alloc(1'b1, 5'd15, 1'b0, 32'h55);
    do_wb(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    check("dup_pre", 64'(wb_err), 64'd0);
    wb1_valid = 1'b1; wb1_pos = 3'd0; wb1_data = 32'hDEAD;
    tick();
    wb1_valid = 1'b0;
    check("dup_retire", 64'(n_ret), 64'd1);
    check("dup_err", 64'(wb_err), 64'd1);
    reset_pulse();

    // Two buses naming one position are both ignored
    do_alloc(1'b1, 5'd16, 1'b0, 32'h77);
    do_wb(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0);
    check("clash_err", 64'(wb_err), 64'd1);
    tick();
    check("clash_not_done", 64'(n_ret), 64'd0);
    do_wb(1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
    tick();
    check("clash_recover", 64'(n_ret), 64'd1);
    check("final_count", 64'(count), 64'd0);
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
